// File: rtl/knn_sorter_k.sv
// Streaming K-nearest-neighbour sorter: squared-distance pipeline feeding a
// sorted compare-and-shift list of the K closest labelled training points.
module knn_sorter_k #(
  parameter int DATA_W = 16,
  parameter int LABEL_W = 8,
  parameter int K = 4,
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1,
  localparam int DIST_W = 2 * DATA_W + 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [DATA_W-1:0]  test_x,
  input  logic signed [DATA_W-1:0]  test_y,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_x,
  input  logic signed [DATA_W-1:0]  in_y,
  input  logic [LABEL_W-1:0]        in_label,
  input  logic                      finish,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W:0]            count,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      rd_valid,
  output logic [DIST_W-1:0]         rd_dist,
  output logic [LABEL_W-1:0]        rd_label
);

  localparam int SQ_W = 2 * DATA_W + 2;
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(K);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DRAIN, S_DONE} state_t;

  function automatic logic signed [DATA_W:0] diff_ext(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
  endfunction

  // Square of a difference is never negative, so the signed product maps
  // straight onto the unsigned distance range.
  function automatic logic [DIST_W-1:0] square(input logic signed [DATA_W:0] v);
    logic signed [SQ_W-1:0] p;
    p = SQ_W'(v) * SQ_W'(v);
    return DIST_W'($unsigned(p));
  endfunction

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] test_x_q, test_y_q;
  logic signed [DATA_W:0]   dx_p1, dy_p1;
  logic [LABEL_W-1:0]       label_p1, label_p2;
  logic [DIST_W-1:0]        dist_p2;
  logic                     vld_p1, vld_p2;

  logic [DIST_W-1:0]  ldist   [K];
  logic [LABEL_W-1:0] llabel  [K];
  logic [K-1:0]       lvld;
  logic [DIST_W-1:0]  ldist_n [K];
  logic [LABEL_W-1:0] llabel_n[K];
  logic [K-1:0]       lvld_n;
  logic [K-1:0]       gt;
  logic [K:0]         gtx;
  logic               ins_en;
  logic               xfer;

  assign in_ready = (state_q == S_ACCEPT);
  assign busy     = (state_q == S_ACCEPT) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_ACCEPT;
    end else begin
      case (state_q)
        S_ACCEPT: if (finish) state_d = S_DRAIN;
        // S2 drains on the same edge, so an empty S1 means the list is final.
        S_DRAIN:  if (!vld_p1) state_d = S_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Slot i takes the new point when it is the first "greater" slot and
  // takes slot i-1's entry when an earlier slot already was.
  always_comb begin
    ldist_n  = ldist;
    llabel_n = llabel;
    lvld_n   = lvld;
    for (int i = 0; i < K; i++) begin
      gt[i] = !lvld[i] || (ldist[i] > dist_p2);
    end
    gtx = {gt, 1'b0};
    for (int i = 0; i < K; i++) begin
      if (gt[i] && !gtx[i]) begin
        ldist_n[i]  = dist_p2;
        llabel_n[i] = label_p2;
        lvld_n[i]   = 1'b1;
      end
    end
    for (int i = 1; i < K; i++) begin
      if (gt[i] && gtx[i]) begin
        ldist_n[i]  = ldist[i-1];
        llabel_n[i] = llabel[i-1];
        lvld_n[i]   = lvld[i-1];
      end
    end
    ins_en = vld_p2 && (|gt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      lvld     <= '0;
      count    <= '0;
      test_x_q <= '0;
      test_y_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        test_x_q <= test_x;
        test_y_q <= test_y;
        vld_p1   <= 1'b0;
        vld_p2   <= 1'b0;
        lvld     <= '0;
        count    <= '0;
      end else begin
        vld_p1 <= xfer;
        vld_p2 <= vld_p1;
        if (ins_en) begin
          lvld <= lvld_n;
          if (count != CNT_MAX) count <= count + (IDX_W + 1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // S1: per-axis differences
    dx_p1    <= diff_ext(in_x, test_x_q);
    dy_p1    <= diff_ext(in_y, test_y_q);
    label_p1 <= in_label;
    // S2: squared distance
    dist_p2  <= square(dx_p1) + square(dy_p1);
    label_p2 <= label_p1;
    // S3: sorted insertion
    if (ins_en) begin
      ldist  <= ldist_n;
      llabel <= llabel_n;
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_dist  = '0;
    rd_label = '0;
    for (int i = 0; i < K; i++) begin
      if (rd_idx == IDX_W'(i) && lvld[i]) begin
        rd_valid = 1'b1;
        rd_dist  = ldist[i];
        rd_label = llabel[i];
      end
    end
  end

endmodule

// File: tb/tb_knn_sorter_k.sv
// Bench for knn_sorter_k: fixed vector table, randomized runs against a
// sorted-queue reference, and hand sequences for reset/restart/drain corners.
module tb_knn_sorter_k;

  localparam int DW  = 16;
  localparam int LW  = 8;
  localparam int KK  = 4;
  localparam int IW  = 2;
  localparam int DSW = 2 * DW + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic finish = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] test_x = '0, test_y = '0, in_x = '0, in_y = '0;
  logic [LW-1:0] in_label = '0;
  logic [IW-1:0] rd_idx = '0;
  logic in_ready, busy, done, rd_valid;
  logic [IW:0] count;
  logic [DSW-1:0] rd_dist;
  logic [LW-1:0] rd_label;

  knn_sorter_k #(.DATA_W(DW), .LABEL_W(LW), .K(KK)) dut (
    .clk(clk), .rst(rst), .start(start), .test_x(test_x), .test_y(test_y),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_label(in_label), .finish(finish), .busy(busy), .done(done),
    .count(count), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_dist(rd_dist),
    .rd_label(rd_label)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {longint d; int l;} ent_t;
  ent_t mq[$];

  typedef struct packed {
    logic signed [15:0] tx;
    logic signed [15:0] ty;
    logic [3:0]          n;
    logic [5:0][15:0]    px;
    logic [5:0][15:0]    py;
    logic [5:0][7:0]     pl;
    logic [3:0][34:0]    ed;
    logic [3:0][7:0]     el;
    logic [2:0]          ec;
  } vec_t;
  vec_t tbl[5];

  int sx[8], sy[8], sl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic setp(input int v, input int i, input int x, input int y, input int l);
    tbl[v].px[i] = 16'(x);
    tbl[v].py[i] = 16'(y);
    tbl[v].pl[i] = 8'(l);
  endtask

  task automatic sete(input int v, input int i, input longint d, input int l);
    tbl[v].ed[i] = DSW'(d);
    tbl[v].el[i] = 8'(l);
  endtask

  // Reference: keep the K smallest distances in arrival-stable order.
  task automatic model_ins(input longint d, input int l);
    int p;
    ent_t e;
    p = mq.size();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].d > d) begin
        p = i;
        break;
      end
    end
    if (p < KK) begin
      e.d = d;
      e.l = l;
      mq.insert(p, e);
      if (mq.size() > KK) void'(mq.pop_back());
    end
  endtask

  task automatic push(input int x, input int y, input int l, input bit fin);
    in_valid = 1'b1;
    in_x = DW'(x);
    in_y = DW'(y);
    in_label = LW'(l);
    finish = fin;
    @(negedge clk);
    in_valid = 1'b0;
    finish = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic read_at(input int idx);
    rd_idx = IW'(idx);
    #1;
  endtask

  // Called at a negedge; streams sx/sy/sl, finish on the last transfer.
  task automatic run(input int tx, input int ty, input int n, input bit gaps, input string tag);
    int i, lat;
    longint dx, dy;
    start = 1'b1;
    test_x = DW'(tx);
    test_y = DW'(ty);
    @(negedge clk);
    start = 1'b0;
    mq.delete();
    i = 0;
    while (i < n) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        finish = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_x = DW'(sx[i]);
        in_y = DW'(sy[i]);
        in_label = LW'(sl[i]);
        finish = (i == n - 1);
        chk({tag, "_rdy"}, in_ready, 1);
        dx = sx[i] - tx;
        dy = sy[i] - ty;
        model_ins(dx * dx + dy * dy, sl[i]);
        i++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_lat"}, lat, 3);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cnt"}, count, mq.size());
    for (int idx = 0; idx < KK; idx++) begin
      read_at(idx);
      if (idx < mq.size()) begin
        chk($sformatf("%s_v%0d", tag, idx), rd_valid, 1);
        chk($sformatf("%s_d%0d", tag, idx), rd_dist, mq[idx].d);
        chk($sformatf("%s_l%0d", tag, idx), rd_label, mq[idx].l);
      end else begin
        chk($sformatf("%s_v%0d", tag, idx), rd_valid, 0);
        chk($sformatf("%s_d%0d", tag, idx), rd_dist, 0);
        chk($sformatf("%s_l%0d", tag, idx), rd_label, 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    for (int v = 0; v < 5; v++) tbl[v] = '0;
    // basic sort
    tbl[0].tx = 0; tbl[0].ty = 0; tbl[0].n = 5; tbl[0].ec = 4;
    setp(0, 0, 3, 4, 1); setp(0, 1, 1, 1, 2); setp(0, 2, -2, 0, 3);
    setp(0, 3, 0, -5, 4); setp(0, 4, 1, 0, 5);
    sete(0, 0, 1, 5); sete(0, 1, 2, 2); sete(0, 2, 4, 3); sete(0, 3, 25, 1);
    // ties and saturation
    tbl[1].tx = 0; tbl[1].ty = 0; tbl[1].n = 5; tbl[1].ec = 4;
    setp(1, 0, 1, 1, 10); setp(1, 1, -1, 1, 11); setp(1, 2, 1, -1, 12);
    setp(1, 3, -1, -1, 13); setp(1, 4, 1, 1, 14);
    sete(1, 0, 2, 10); sete(1, 1, 2, 11); sete(1, 2, 2, 12); sete(1, 3, 2, 13);
    // extremes
    tbl[2].tx = -32768; tbl[2].ty = -32768; tbl[2].n = 1; tbl[2].ec = 1;
    setp(2, 0, 32767, 32767, 7);
    sete(2, 0, 64'd8589672450, 7);
    // underfill
    tbl[3].tx = 10; tbl[3].ty = -10; tbl[3].n = 2; tbl[3].ec = 2;
    setp(3, 0, 12, -10, 1); setp(3, 1, 10, -7, 2);
    sete(3, 0, 4, 1); sete(3, 1, 9, 2);
    // descending arrival, one far point rejected
    tbl[4].tx = 5; tbl[4].ty = 5; tbl[4].n = 6; tbl[4].ec = 4;
    setp(4, 0, 5, 9, 1); setp(4, 1, 5, 8, 2); setp(4, 2, 5, 7, 3);
    setp(4, 3, 5, 6, 4); setp(4, 4, 5, 5, 5); setp(4, 5, 0, 0, 6);
    sete(4, 0, 0, 5); sete(4, 1, 1, 4); sete(4, 2, 4, 3); sete(4, 3, 9, 2);

    rst = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    for (int idx = 0; idx < KK; idx++) begin
      read_at(idx);
      chk($sformatf("rst_rdv%0d", idx), rd_valid, 0);
    end

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < int'(tbl[v].n); i++) begin
        sx[i] = int'($signed(tbl[v].px[i]));
        sy[i] = int'($signed(tbl[v].py[i]));
        sl[i] = int'(tbl[v].pl[i]);
      end
      run(int'(tbl[v].tx), int'(tbl[v].ty), int'(tbl[v].n), 1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_busy", v), busy, 0);
      chk($sformatf("vec%0d_cnt", v), count, tbl[v].ec);
      for (int idx = 0; idx < KK; idx++) begin
        read_at(idx);
        chk($sformatf("vec%0d_v%0d", v, idx), rd_valid, (idx < int'(tbl[v].ec)) ? 1 : 0);
        chk($sformatf("vec%0d_d%0d", v, idx), rd_dist, tbl[v].ed[idx]);
        chk($sformatf("vec%0d_l%0d", v, idx), rd_label, tbl[v].el[idx]);
      end
    end

    // DONE ignores further in_valid
    sx[0] = 1; sy[0] = 0; sl[0] = 33;
    run(0, 0, 1, 1'b0, "frz");
    chk("frz_in_ready", in_ready, 0);
    in_valid = 1'b1; in_x = 0; in_y = 0; in_label = 99;
    wait_cycles(3);
    in_valid = 1'b0;
    wait_cycles(4);
    chk("frz_done", done, 1);
    check_model("frz");

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      int n, tx, ty;
      bit wide;
      wide = (r % 5 == 4);
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        if (wide) begin
          sx[i] = int'($urandom_range(0, 65535)) - 32768;
          sy[i] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          sx[i] = int'($urandom_range(0, 12)) - 6;
          sy[i] = int'($urandom_range(0, 12)) - 6;
        end
        sl[i] = int'($urandom_range(0, 255));
      end
      tx = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4)) - 2;
      ty = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4)) - 2;
      run(tx, ty, n, r[0], $sformatf("rnd%0d", r));
      check_model($sformatf("rnd%0d", r));
    end

    // reset mid-ACCEPT with stimulus still active
    start = 1'b1; test_x = 0; test_y = 0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_x = 1; in_y = 1; in_label = 5;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_count", count, 0);
    wait_cycles(4);
    in_valid = 1'b0;
    chk("mrst_count_late", count, 0);
    for (int idx = 0; idx < KK; idx++) begin
      read_at(idx);
      chk($sformatf("mrst_rdv%0d", idx), rd_valid, 0);
    end

    // start concurrent with finish: restart wins
    start = 1'b1; test_x = 0; test_y = 0;
    @(negedge clk);
    start = 1'b0;
    push(1, 0, 1, 1'b0);
    push(2, 0, 2, 1'b0);
    wait_cycles(3);
    chk("sf_pre_cnt", count, 2);
    start = 1'b1; finish = 1'b1;
    @(negedge clk);
    start = 1'b0; finish = 1'b0;
    chk("sf_in_ready", in_ready, 1);
    chk("sf_busy", busy, 1);
    chk("sf_count", count, 0);
    read_at(0);
    chk("sf_rdv0", rd_valid, 0);
    wait_cycles(4);
    chk("sf_still_accept", in_ready, 1);
    chk("sf_not_done", done, 0);

    // start during DRAIN drops in-flight points
    start = 1'b1; test_x = 0; test_y = 0;
    @(negedge clk);
    start = 1'b0;
    push(1, 0, 1, 1'b0);
    push(2, 0, 2, 1'b0);
    push(3, 0, 3, 1'b1);
    chk("sd_drain_rdy", in_ready, 0);
    chk("sd_drain_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sd_count", count, 0);
    chk("sd_in_ready", in_ready, 1);
    wait_cycles(4);
    chk("sd_count_late", count, 0);
    read_at(0);
    chk("sd_rdv0", rd_valid, 0);
    chk("sd_not_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_sorter_k.md
Name: knn_sorter_k

Overview:
- Parametrised successor to the single-pair KNN core. Holds one test point and accepts a stream of labelled 2-D training points.
- For each training point it computes the exact squared Euclidean distance to the test point. It maintains a sorted list of the K nearest points, with their labels, in a compare-and-shift register array.
- Sits behind the KNN software register file. The CPU streams points in and reads results back by index.

Parameters:
- DATA_W, 16, signed coordinate width (two's complement)
- LABEL_W, 8, training label width
- K, 4, number of neighbours kept (K >= 1)
- IDX_W, $clog2(K) with minimum 1, read-index width (derived, not overridden)
- DIST_W, 2*DATA_W+3, squared-distance width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  pulse: latch test point, clear list, enter ACCEPT
- test_x  in  DATA_W  test point X, sampled on start
- test_y  in  DATA_W  test point Y, sampled on start
- in_valid  in  1  training point valid
- in_ready  out  1  block accepts a training point this cycle
- in_x  in  DATA_W  training X
- in_y  in  DATA_W  training Y
- in_label  in  LABEL_W  training label
- finish  in  1  pulse: no more points; drain then assert done
- busy  out  1  high in ACCEPT or DRAIN
- done  out  1  list final; high in DONE
- count  out  IDX_W+1  number of valid entries, saturates at K
- rd_idx  in  IDX_W  result entry select (0 = nearest)
- rd_valid  out  1  selected entry valid
- rd_dist  out  DIST_W  selected entry distance
- rd_label  out  LABEL_W  selected entry label

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE.
  - in_ready, busy, done, count = 0.
  - All list valid bits = 0; pipeline valid bits = 0; test point regs = 0.
  - Reset mid-operation discards everything.
- States:
  - IDLE --start--> ACCEPT.
  - ACCEPT --finish--> DRAIN.
  - DRAIN --pipeline empty--> DONE.
  - DONE --start--> ACCEPT.
  - start in any non-reset state acts as a restart: latch test point, clear list and pipeline valids, count=0, enter ACCEPT.
- start and finish in the same cycle: start wins; finish is ignored.
- in_ready = 1 only in ACCEPT; combinational from state.
- Transfer occurs when in_valid & in_ready.
- in_valid & in_ready with finish in the same cycle: the point is accepted and included in the result.
- Pipeline, one transfer per cycle, no stalls:
  - S1 (cycle after transfer): dx = in_x - test_x and dy = in_y - test_y, each sign-extended to DATA_W+1 bits; label registered.
  - S2: dist = dx*dx + dy*dy, unsigned DIST_W; no overflow is possible.
  - S3: insertion into the list.
  - A point is visible on the read port 3 cycles after its transfer.
- Insertion (single cycle, all K slots in parallel):
  - Invalid slots compare as infinite distance.
  - New point goes to slot p, the first slot whose entry is invalid or has dist strictly greater than the new dist.
  - Slots p..K-2 shift down by one; the old slot K-1 is discarded.
  - If no such p exists, the list is unchanged.
  - Ties: the earlier-arrived entry stays nearer (stable).
- count increments on each insertion until it reaches K, then holds.
- DRAIN: in_ready=0. Move to DONE on the first cycle in which S1 and S2 are both empty. Worst case is 3 cycles after finish.
- DONE: done=1, busy=0, list frozen. in_valid is ignored.
- Read port:
  - Combinational from list registers for any rd_idx, in any state.
  - rd_idx >= K gives rd_valid=0, rd_dist=0, rd_label=0.
  - An invalid slot also reads 0.

Test Plan:
- Reset with stimulus active: rst=0 for 2 cycles mid-ACCEPT, then release -> state IDLE, in_ready=0, done=0, count=0, rd_valid=0 for all rd_idx.
- Basic sort (K=4): test point (0,0); stream (3,4,L1), (1,1,L2), (-2,0,L3), (0,-5,L4), (1,0,L5), then finish -> done 3 cycles later.
  - Entries 0..3 dist/label = 1/L5, 2/L2, 4/L3, 25/L1; count=4.
  - (0,-5) is discarded because it ties the ejected 25 and arrived later.
- Ties and saturation: five points all at dist 2 -> list holds the first four in arrival order; count=4 and does not wrap.
- Extremes (DATA_W=16): test (-32768,-32768), point (32767,32767) -> rd_dist = 2*65535^2 = 8589672450, no truncation.
- Boundary control:
  - finish in the same cycle as the last transfer -> that point is included.
  - start concurrent with finish -> ACCEPT, list cleared.
  - start during DRAIN -> in-flight points are dropped; count=0.
- Underfill: 2 points with finish -> count=2; rd_idx 2,3 give rd_valid=0; back-to-back in_valid every cycle is accepted with no stall.
